// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: states, instruction classes, opcode/funct and control code constants
package mc_ctrl_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP
   } state_e;
   typedef enum logic [2:0] {CL_R, CL_I, CL_MEM, CL_BR, CL_J, CL_ILL} class_e;
   localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
      OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
      OP_ANDI = 6'b001100, OP_LH = 6'b100001, OP_LW = 6'b100011, OP_SH = 6'b101001,
      OP_SW = 6'b101011;
   localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_JR = 6'b001000,
      F_JALR = 6'b001001, F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
      F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111, F_SLT = 6'b101010;
   localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000,
      ALU_OR = 4'b0001, ALU_NOR = 4'b1100, ALU_SLT = 4'b0111, ALU_SLL = 4'b0100,
      ALU_SRL = 4'b0101, ALU_XOR = 4'b0011, ALU_PASS = 4'b1111;
   localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM2 = 2'b11;
   localparam logic [1:0] PCS_ALU = 2'b00, PCS_OUT = 2'b01, PCS_JMP = 2'b10, PCS_REG = 2'b11;

   function automatic class_e op_class(input logic [5:0] op, input logic [5:0] fn);
      class_e c;
      c = CL_ILL;
      case (op)
         OP_R: case (fn)
            F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT: c = CL_R;
            F_JR, F_JALR: c = CL_J;
            default: c = CL_ILL;
         endcase
         OP_ADDI, OP_ANDI, OP_SLTI: c = CL_I;
         OP_LW, OP_LH, OP_SW, OP_SH: c = CL_MEM;
         OP_BEQ, OP_BNE: c = CL_BR;
         OP_J, OP_JAL: c = CL_J;
         default: c = CL_ILL;
      endcase
      return c;
   endfunction
endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: ALUOp for EXEC_R (from funct) and EXEC_I (from opcode)
module mc_alu_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alu_op_o
);
   always_comb begin
      alu_op_o = ALU_ADD;
      if (opcode_i == OP_R)
         case (funct_i)
            F_SUB: alu_op_o = ALU_SUB;
            F_AND: alu_op_o = ALU_AND;
            F_OR:  alu_op_o = ALU_OR;
            F_NOR: alu_op_o = ALU_NOR;
            F_SLT: alu_op_o = ALU_SLT;
            F_SLL: alu_op_o = ALU_SLL;
            F_SRL: alu_op_o = ALU_SRL;
            F_XOR: alu_op_o = ALU_XOR;
            default: alu_op_o = ALU_ADD;
         endcase
      else
         alu_op_o = opcode_i == OP_ANDI ? ALU_AND : opcode_i == OP_SLTI ? ALU_SLT : ALU_ADD;
   end
endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: sequencing FSM for the multi-cycle MIPS datapath
module multi_cycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter bit RESET_TO_IDLE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       BranchNE,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       to_reg31,
   output logic       SH,
   output logic       LH,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op
);
   state_e state_q, state_d, st;
   class_e cls;
   logic [3:0] dec_op;
   logic is_link;

   mc_alu_decode u_dec (.opcode_i(opcode), .funct_i(funct), .alu_op_o(dec_op));

   assign cls = op_class(opcode, funct);
   assign is_link = opcode == OP_JAL || (opcode == OP_R && funct == F_JALR);
   // outputs follow IDLE while reset is held so every strobe drops at once
   assign st = rst ? state_q : S_IDLE;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state_q <= RESET_TO_IDLE ? S_IDLE : S_FETCH;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite} = '0;
      {MemtoReg, RegDst, RegWrite, ALUSrcA, to_reg31, SH, LH, illegal_op} = '0;
      ALUSrcB = SRCB_B;
      ALUOp = ALU_AND;
      PCSource = PCS_ALU;
      case (st)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_4;
            ALUOp = ALU_ADD;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            state_d = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM2;
            ALUOp = ALU_ADD;
            illegal_op = cls == CL_ILL;
            state_d = cls == CL_R ? S_EXEC_R : cls == CL_I ? S_EXEC_I :
                      cls == CL_MEM ? S_MEM_ADDR : cls == CL_BR ? S_BRANCH :
                      cls == CL_J ? S_JUMP : S_FETCH;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp = dec_op;
            state_d = S_WB_ALU;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp = dec_op;
            state_d = S_WB_ALU;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp = ALU_ADD;
            state_d = opcode == OP_SW || opcode == OP_SH ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD = 1'b1;
            LH = opcode == OP_LH;
            state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD = 1'b1;
            SH = opcode == OP_SH;
            state_d = mem_ready ? S_FETCH : S_MEM_WR;
         end
         S_WB_ALU: begin
            RegWrite = 1'b1;
            RegDst = opcode == OP_R;
            state_d = S_FETCH;
         end
         S_WB_MEM: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            LH = opcode == OP_LH;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUOp = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource = PCS_OUT;
            BranchNE = opcode == OP_BNE;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            PCWrite = 1'b1;
            ALUOp = ALU_PASS;
            PCSource = opcode == OP_R ? PCS_REG : PCS_JMP;
            RegWrite = is_link;
            to_reg31 = is_link;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: per-cycle output vectors for each instruction class
module tb_multi_cycle_controller;
   typedef struct packed {
      logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, r31, sh, lh;
      logic [1:0] srcb;
      logic [3:0] aluop;
      logic [1:0] pcsrc;
      logic ill;
   } ctl_t;
   typedef struct {
      logic r;
      logic [5:0] op;
      logic [5:0] fn;
      logic rdy;
      ctl_t exp;
   } vec_t;

   localparam ctl_t C_ZERO = '0;
   localparam ctl_t C_FR = '{mrd:1'b1, irw:1'b1, pcw:1'b1, srcb:2'b01, aluop:4'b0010, default:'0};
   localparam ctl_t C_FW = '{mrd:1'b1, srcb:2'b01, aluop:4'b0010, default:'0};
   localparam ctl_t C_DEC = '{srcb:2'b11, aluop:4'b0010, default:'0};
   localparam ctl_t C_ILL = '{srcb:2'b11, aluop:4'b0010, ill:1'b1, default:'0};
   localparam ctl_t C_ER_ADD = '{srca:1'b1, aluop:4'b0010, default:'0};
   localparam ctl_t C_ER_NOR = '{srca:1'b1, aluop:4'b1100, default:'0};
   localparam ctl_t C_EI_SLT = '{srca:1'b1, srcb:2'b10, aluop:4'b0111, default:'0};
   localparam ctl_t C_MA = '{srca:1'b1, srcb:2'b10, aluop:4'b0010, default:'0};
   localparam ctl_t C_MRD = '{mrd:1'b1, iord:1'b1, default:'0};
   localparam ctl_t C_MRD_LH = '{mrd:1'b1, iord:1'b1, lh:1'b1, default:'0};
   localparam ctl_t C_MWR = '{mwr:1'b1, iord:1'b1, default:'0};
   localparam ctl_t C_MWR_SH = '{mwr:1'b1, iord:1'b1, sh:1'b1, default:'0};
   localparam ctl_t C_WBR = '{rw:1'b1, rdst:1'b1, default:'0};
   localparam ctl_t C_WBI = '{rw:1'b1, default:'0};
   localparam ctl_t C_WBM = '{rw:1'b1, m2r:1'b1, default:'0};
   localparam ctl_t C_WBM_LH = '{rw:1'b1, m2r:1'b1, lh:1'b1, default:'0};
   localparam ctl_t C_BEQ = '{srca:1'b1, aluop:4'b0110, pcwc:1'b1, pcsrc:2'b01, default:'0};
   localparam ctl_t C_BNE = '{srca:1'b1, aluop:4'b0110, pcwc:1'b1, pcsrc:2'b01, bne:1'b1, default:'0};
   localparam ctl_t C_JAL = '{pcw:1'b1, aluop:4'b1111, pcsrc:2'b10, rw:1'b1, r31:1'b1, default:'0};
   localparam ctl_t C_JR = '{pcw:1'b1, aluop:4'b1111, pcsrc:2'b11, default:'0};

   logic clk = 1'b0, rst = 1'b0, mem_ready = 1'b0;
   logic [5:0] opcode = '0, funct = '0;
   logic PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
   logic MemtoReg, RegDst, RegWrite, ALUSrcA, to_reg31, SH, LH, illegal_op;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] ALUOp;
   ctl_t act;
   vec_t v[$];
   int checks = 0, errors = 0;

   multi_cycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
      .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .to_reg31(to_reg31),
      .SH(SH), .LH(LH), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign act = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, to_reg31, SH, LH, ALUSrcB, ALUOp, PCSource, illegal_op};

   task automatic chk(input string nm, input ctl_t e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, e);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input ctl_t e);
      v.push_back('{1'b1, op, fn, rdy, e});
   endtask

   initial begin
      add(6'h00, 6'h00, 1'b1, C_ZERO);
      // add: 4 cycles
      add(6'b000000, 6'b100000, 1'b1, C_FR);
      add(6'b000000, 6'b100000, 1'b1, C_DEC);
      add(6'b000000, 6'b100000, 1'b1, C_ER_ADD);
      add(6'b000000, 6'b100000, 1'b1, C_WBR);
      // lw with two wait cycles in MEM_RD: 7 cycles
      add(6'b100011, 6'b000000, 1'b1, C_FR);
      add(6'b100011, 6'b000000, 1'b0, C_DEC);
      add(6'b100011, 6'b000000, 1'b0, C_MA);
      add(6'b100011, 6'b000000, 1'b0, C_MRD);
      add(6'b100011, 6'b000000, 1'b0, C_MRD);
      add(6'b100011, 6'b000000, 1'b1, C_MRD);
      add(6'b100011, 6'b000000, 1'b0, C_WBM);
      add(6'b000100, 6'b000000, 1'b1, C_FR);
      add(6'b000100, 6'b000000, 1'b1, C_DEC);
      add(6'b000100, 6'b000000, 1'b1, C_BEQ);
      add(6'b000101, 6'b000000, 1'b1, C_FR);
      add(6'b000101, 6'b000000, 1'b1, C_DEC);
      add(6'b000101, 6'b000000, 1'b1, C_BNE);
      add(6'b000011, 6'b000000, 1'b1, C_FR);
      add(6'b000011, 6'b000000, 1'b1, C_DEC);
      add(6'b000011, 6'b000000, 1'b1, C_JAL);
      // jr preceded by one FETCH wait cycle
      add(6'b000000, 6'b001000, 1'b0, C_FW);
      add(6'b000000, 6'b001000, 1'b1, C_FR);
      add(6'b000000, 6'b001000, 1'b1, C_DEC);
      add(6'b000000, 6'b001000, 1'b1, C_JR);
      add(6'b111111, 6'b000000, 1'b1, C_FR);
      add(6'b111111, 6'b000000, 1'b1, C_ILL);
      add(6'b001010, 6'b000000, 1'b1, C_FR);
      add(6'b001010, 6'b000000, 1'b1, C_DEC);
      add(6'b001010, 6'b000000, 1'b1, C_EI_SLT);
      add(6'b001010, 6'b000000, 1'b1, C_WBI);
      add(6'b000000, 6'b100111, 1'b1, C_FR);
      add(6'b000000, 6'b100111, 1'b1, C_DEC);
      add(6'b000000, 6'b100111, 1'b1, C_ER_NOR);
      add(6'b000000, 6'b100111, 1'b1, C_WBR);
      add(6'b100001, 6'b000000, 1'b1, C_FR);
      add(6'b100001, 6'b000000, 1'b1, C_DEC);
      add(6'b100001, 6'b000000, 1'b1, C_MA);
      add(6'b100001, 6'b000000, 1'b1, C_MRD_LH);
      add(6'b100001, 6'b000000, 1'b1, C_WBM_LH);
      add(6'b101001, 6'b000000, 1'b1, C_FR);
      add(6'b101001, 6'b000000, 1'b1, C_DEC);
      add(6'b101001, 6'b000000, 1'b1, C_MA);
      add(6'b101001, 6'b000000, 1'b1, C_MWR_SH);
      add(6'b101011, 6'b000000, 1'b1, C_FR);
      add(6'b101011, 6'b000000, 1'b1, C_DEC);
      add(6'b101011, 6'b000000, 1'b1, C_MA);

      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1 chk("in_reset", C_ZERO);
      foreach (v[i]) begin
         @(negedge clk);
         rst = v[i].r;
         opcode = v[i].op;
         funct = v[i].fn;
         mem_ready = v[i].rdy;
         #1 chk($sformatf("row%0d", i), v[i].exp);
      end
      // sw stalled in MEM_WR, then reset mid-cycle
      @(negedge clk);
      mem_ready = 1'b0;
      #1 chk("sw_mem_wr", C_MWR);
      #1 rst = 1'b0;
      #1 chk("async_reset", C_ZERO);
      @(negedge clk);
      mem_ready = 1'b1;
      #1 chk("reset_held", C_ZERO);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("idle_after_reset", C_ZERO);
      @(negedge clk);
      #1 chk("fetch_after_idle", C_FR);
      @(negedge clk);
      #1 chk("decode_after_restart", C_DEC);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
